// File: rtl/data_sram_axi_bridge_if.sv
// AXI4 bus bundle for the data-side bridge (single-beat, one outstanding).
//
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where both valid and ready are 1. The source raises valid without
// waiting for ready, then holds valid and the whole payload stable until
// that edge. The sink may raise or lower ready freely.
interface data_sram_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/data_sram_axi_bridge.sv
// Data-side SRAM-style request to single-beat AXI4 bridge.
// Each accepted request becomes exactly one AXI read or write; the pipeline
// is stalled until the transaction completes, then released for one DONE
// cycle in which it advances. Only one transaction is ever in flight.
module data_sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_pc,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic [2:0]  dbg_state,
  output logic [31:0] dbg_pc,
  data_sram_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic [31:0] rdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done_q;
  logic        w_done_q;

  logic        req_take;
  logic        aw_fire;
  logic        w_fire;
  logic        r_fire;

  // Response status and rlast are deliberately not acted upon.
  logic        unused_resp;
  assign unused_resp = ^{axi.rresp, axi.rlast, axi.bresp};

  assign req_take = (state_q == IDLE) && data_sram_en;
  assign aw_fire  = (state_q == WR_REQ) && !aw_done_q && axi.awready;
  assign w_fire   = (state_q == WR_REQ) && !w_done_q && axi.wready;
  assign r_fire   = (state_q == RD_DATA) && axi.rvalid;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_sram_en) state_d = (data_sram_wen == 4'b0000) ? RD_ADDR : WR_REQ;
      RD_ADDR: if (axi.arready) state_d = RD_DATA;
      RD_DATA: if (axi.rvalid) state_d = DONE;
      WR_REQ:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WR_RESP;
      WR_RESP: if (axi.bvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture in IDLE; the pipeline's inputs are not trusted after this.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      pc_q    <= 32'd0;
    end else if (req_take) begin
      addr_q  <= data_sram_addr;
      wdata_q <= data_sram_wdata;
      wstrb_q <= data_sram_wen;
      pc_q    <= data_sram_pc;
    end
  end

  // Load data register, updated only when R data is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     rdata_q <= 32'd0;
    else if (r_fire) rdata_q <= axi.rdata;
  end

  // AW and W complete independently; flags clear whenever we leave WR_REQ.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (state_q == WR_REQ) begin
      aw_done_q <= aw_done_q || aw_fire;
      w_done_q  <= w_done_q || w_fire;
    end else begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end
  end

  // Channel valids/readies and stall, all decoded from registered state so
  // the asynchronous reset removes them without a clock edge.
  always_comb begin
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    stallreq    = 1'b0;
    case (state_q)
      IDLE:    stallreq = data_sram_en;
      RD_ADDR: begin axi.arvalid = 1'b1; stallreq = 1'b1; end
      RD_DATA: begin axi.rready = 1'b1; stallreq = 1'b1; end
      WR_REQ: begin
        axi.awvalid = !aw_done_q;
        axi.wvalid  = !w_done_q;
        stallreq    = 1'b1;
      end
      WR_RESP: begin axi.bready = 1'b1; stallreq = 1'b1; end
      default: stallreq = 1'b0;
    endcase
    // A request presented while reset is held must not stall the pipeline.
    if (!resetn) stallreq = 1'b0;
  end

  // Write transfer size follows the number of enabled byte lanes.
  always_comb begin
    case (wstrb_q)
      4'b1111:          axi.awsize = 3'd2;
      4'b0011, 4'b1100: axi.awsize = 3'd1;
      default:          axi.awsize = 3'd0;
    endcase
  end

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = {addr_q[31:2], 2'b00};
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'd2;
  assign axi.arburst = 2'b01;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awburst = 2'b01;

  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;

  assign data_sram_rdata = rdata_q;
  assign dbg_state       = state_q;
  assign dbg_pc          = pc_q;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Bench for data_sram_axi_bridge: a bench-side AXI slave with programmable
// per-channel ready/valid delays, and a reference model that predicts the
// transaction, its payload, the stall length and the returned load data.
module tb_data_sram_axi_bridge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] rdata_o;
  logic        stallreq;
  logic [2:0]  dbg_state;
  logic [31:0] dbg_pc;

  data_sram_axi_bridge_if axi ();

  data_sram_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_pc    (pc),
    .data_sram_rdata (rdata_o),
    .stallreq        (stallreq),
    .dbg_state       (dbg_state),
    .dbg_pc          (dbg_pc),
    .axi             (axi)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata = 32'd0;
  logic [3:0]  strb_tab [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  // Transfer size = log2(bytes enabled).
  function automatic logic [2:0] exp_size(input logic [3:0] strb);
    int nb;
    nb = $countones(strb);
    return (nb == 4) ? 3'd2 : (nb == 2) ? 3'd1 : 3'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic slave_idle();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = $urandom;
    axi.rresp   = 2'($urandom_range(0, 3));
    axi.rlast   = 1'($urandom_range(0, 1));
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'($urandom_range(0, 3));
  endtask

  // Issues one request at a negedge and plays the slave until DONE.
  // Returns at the following negedge (IDLE cycle) or, if abort_k >= 0,
  // one time unit into cycle abort_k with the transaction still in flight.
  task automatic do_request(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rd_val, input int ar_d, input int r_d,
                            input int aw_d, input int w_d, input int b_d,
                            input bit hold, input int abort_k);
    bit   is_load;
    int   k, stall_n, exp_stall;
    int   ar_hi, r_hi, aw_hi, w_hi, b_hi;
    int   ar_n, r_n, aw_n, w_n, b_n;
    bit   p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, done;
    logic [31:0] exp_rd, exp_pc;
    is_load = (w == 4'b0000);
    en = 1'b1; wen = w; addr = a; wdata = d; pc = $urandom; exp_pc = pc;
    exp_stall = is_load ? 3 + ar_d + r_d : 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
    exp_q.push_back(is_load ? rd_val : last_rdata);
    k = 0; stall_n = 0; done = 0;
    ar_hi = 0; r_hi = 0; aw_hi = 0; w_hi = 0; b_hi = 0;
    ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    while (!done) begin
      #1;
      if (k == abort_k) begin
        void'(exp_q.pop_back());
        return;
      end
      if (k > 0 && !stallreq) begin
        exp_rd = exp_q.pop_front();
        n_vec++;
        if (rdata_o !== exp_rd) begin
          n_err++;
          $display("FAIL done_rdata: got %h expected %h", rdata_o, exp_rd);
        end
        n_vec++;
        if (stall_n != exp_stall) begin
          n_err++;
          $display("FAIL stall_cycles: got %0d expected %0d", stall_n, exp_stall);
        end
        n_vec++;
        if ({ar_n, r_n, aw_n, w_n, b_n} != (is_load ? {32'd1, 32'd1, 32'd0, 32'd0, 32'd0}
                                                    : {32'd0, 32'd0, 32'd1, 32'd1, 32'd1})) begin
          n_err++;
          $display("FAIL txn_count: got ar=%0d r=%0d aw=%0d w=%0d b=%0d expected load=%0d",
                   ar_n, r_n, aw_n, w_n, b_n, is_load);
        end
        n_vec++;
        if ({ar_hi, r_hi, aw_hi, w_hi, b_hi} != (is_load ? {ar_d + 1, r_d + 1, 0, 0, 0}
                                                         : {0, 0, aw_d + 1, w_d + 1, b_d + 1})) begin
          n_err++;
          $display("FAIL valid_cycles: got ar=%0d r=%0d aw=%0d w=%0d b=%0d expected %0d/%0d/%0d/%0d/%0d",
                   ar_hi, r_hi, aw_hi, w_hi, b_hi,
                   is_load ? ar_d + 1 : 0, is_load ? r_d + 1 : 0,
                   is_load ? 0 : aw_d + 1, is_load ? 0 : w_d + 1, is_load ? 0 : b_d + 1);
        end
        last_rdata = exp_rd;
        slave_idle();
        if (!hold) en = 1'b0;
        done = 1;
        @(negedge clk);
      end else begin
        if (stallreq) stall_n++;
        if (k == 0) begin
          n_vec++;
          if ({stallreq, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 6'b100000) begin
            n_err++;
            $display("FAIL idle_accept: got stall/arv/awv/wv/rr/br=%b expected 100000",
                     {stallreq, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready});
          end
        end else begin
          n_vec++;
          if (rdata_o !== last_rdata || dbg_pc !== exp_pc) begin
            n_err++;
            $display("FAIL hold_rdata_pc: got rdata=%h pc=%h expected rdata=%h pc=%h",
                     rdata_o, dbg_pc, last_rdata, exp_pc);
          end
        end
        if (axi.arvalid) begin
          ar_hi++;
          n_vec++;
          if ({axi.araddr, axi.arsize, axi.arlen, axi.arburst, axi.arid} !==
              {a & 32'hFFFF_FFFC, 3'd2, 8'd0, 2'b01, 4'd1}) begin
            n_err++;
            $display("FAIL ar_payload: got addr=%h size=%0d len=%0d burst=%b id=%0d expected addr=%h size=2 len=0 burst=01 id=1",
                     axi.araddr, axi.arsize, axi.arlen, axi.arburst, axi.arid, a & 32'hFFFF_FFFC);
          end
        end
        if (axi.awvalid) begin
          aw_hi++;
          n_vec++;
          if ({axi.awaddr, axi.awsize, axi.awlen, axi.awburst, axi.awid} !==
              {a, exp_size(w), 8'd0, 2'b01, 4'd1}) begin
            n_err++;
            $display("FAIL aw_payload: got addr=%h size=%0d len=%0d burst=%b id=%0d expected addr=%h size=%0d len=0 burst=01 id=1",
                     axi.awaddr, axi.awsize, axi.awlen, axi.awburst, axi.awid, a, exp_size(w));
          end
        end
        if (axi.wvalid) begin
          w_hi++;
          n_vec++;
          if ({axi.wdata, axi.wstrb, axi.wlast} !== {d, w, 1'b1}) begin
            n_err++;
            $display("FAIL w_payload: got data=%h strb=%b last=%b expected data=%h strb=%b last=1",
                     axi.wdata, axi.wstrb, axi.wlast, d, w);
          end
        end
        if ((p_arv && !p_arr) || (p_awv && !p_awr) || (p_wv && !p_wr)) begin
          n_vec++;
          if ({axi.arvalid, axi.awvalid, axi.wvalid} !== ({p_arv && !p_arr, p_awv && !p_awr, p_wv && !p_wr}
                                                          | {axi.arvalid, axi.awvalid, axi.wvalid})
              || (p_arv && !p_arr && !axi.arvalid)) begin
            n_err++;
            $display("FAIL valid_drop: got arv/awv/wv=%b before ready", {axi.arvalid, axi.awvalid, axi.wvalid});
          end
        end
        // Slave responses for the coming edge.
        axi.arready = axi.arvalid && (ar_hi > ar_d);
        axi.awready = axi.awvalid && (aw_hi > aw_d);
        axi.wready  = axi.wvalid && (w_hi > w_d);
        if (axi.rready) r_hi++;
        axi.rvalid = axi.rready && (r_hi > r_d);
        axi.rdata  = axi.rvalid ? rd_val : $urandom;
        if (axi.bready) b_hi++;
        axi.bvalid = axi.bready && (b_hi > b_d);
        ar_n += int'(axi.arready); aw_n += int'(axi.awready); w_n += int'(axi.wready);
        r_n  += int'(axi.rvalid);  b_n  += int'(axi.bvalid);
        p_arv = axi.arvalid; p_arr = axi.arready;
        p_awv = axi.awvalid; p_awr = axi.awready;
        p_wv  = axi.wvalid;  p_wr  = axi.wready;
        if (k > 200) begin
          n_vec++; n_err++;
          $display("FAIL timeout: got no DONE after %0d cycles expected %0d", k, exp_stall);
          void'(exp_q.pop_front());
          slave_idle();
          en = 1'b0;
          done = 1;
        end
        @(negedge clk);
        k++;
      end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    resetn = 1'b0;
    en = 1'b1; wen = 4'b0000; addr = 32'h1234_5678; wdata = $urandom; pc = $urandom;
    slave_idle();
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({stallreq, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 6'b0
        || rdata_o !== 32'd0 || dbg_pc !== 32'd0 || dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got stall/valids=%b rdata=%h pc=%h state=%0d expected all 0",
               {stallreq, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready},
               rdata_o, dbg_pc, dbg_state);
    end
    en = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (stallreq !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_req: got stallreq=%b expected 0", stallreq);
    end
    @(negedge clk);
  endtask

  task automatic test_load_zero_wait();
    do_request(4'b0000, 32'h8000_1006, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_byte_store_delayed();
    do_request(4'b0100, 32'h1000_0002, 32'h00AB_0000, 32'h0, 0, 0, 3, 1, 1, 0, -1);
  endtask

  task automatic test_half_word_store();
    do_request(4'b1100, 32'h2000_0012, 32'hBEEF_0000, 32'h0, 0, 0, 0, 2, 0, 0, -1);
    do_request(4'b1111, 32'h2000_0020, 32'h0123_4567, 32'h0, 0, 0, 1, 0, 2, 0, -1);
  endtask

  task automatic test_back_to_back();
    do_request(4'b0000, 32'h3000_0008, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 1, -1);
    do_request(4'b0011, 32'h3000_000C, 32'h0000_5A5A, 32'h0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_slow_r();
    do_request(4'b0000, 32'h4000_0100, 32'h0, 32'h1357_9BDF, 1, 9, 0, 0, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [3:0] w;
      w = ($urandom_range(0, 2) == 0) ? 4'b0000 : strb_tab[$urandom_range(0, 6)];
      do_request(w, $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
      if (!en) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_pulse_check(input string tag);
    #1 resetn = 1'b0;
    #1;
    n_vec++;
    if ({stallreq, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 6'b0
        || rdata_o !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset_%s: got stall/valids=%b rdata=%h expected 000000 and 0", tag,
               {stallreq, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, rdata_o);
    end
    last_rdata = 32'd0;
    slave_idle();
    en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (dbg_state !== 3'd0 || stallreq !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_%s: got state=%0d stall=%b expected 0 0", tag, dbg_state, stallreq);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    // Prime rdata so the reset clear is visible.
    do_request(4'b0000, 32'h5000_0000, 32'h0, 32'hA5A5_1234, 0, 0, 0, 0, 0, 0, -1);
    do_request(4'b0000, 32'h5000_0004, 32'h0, 32'h0BAD_F00D, 0, 8, 0, 0, 0, 0, 3);
    n_vec++;
    if ({axi.rready, stallreq} !== 2'b11) begin
      n_err++;
      $display("FAIL in_rd_data: got rready/stall=%b expected 11", {axi.rready, stallreq});
    end
    reset_pulse_check("rd_data");
    do_request(4'b1111, 32'h5000_0010, 32'h7777_8888, 32'h0, 0, 0, 5, 5, 0, 0, 2);
    n_vec++;
    if ({axi.awvalid, axi.wvalid, stallreq} !== 3'b111) begin
      n_err++;
      $display("FAIL in_wr_req: got awv/wv/stall=%b expected 111", {axi.awvalid, axi.wvalid, stallreq});
    end
    reset_pulse_check("wr_req");
    do_request(4'b0000, 32'h5000_0020, 32'h0, 32'h2468_ACE0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load_zero_wait();
    test_byte_store_delayed();
    test_half_word_store();
    test_back_to_back();
    test_slow_r();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_sram_axi_bridge.md
Name: data_sram_axi_bridge

Overview:
- Responder for the data-side SRAM-style request interface driven by the DT stage (en, wen, addr, wdata, pc).
- Converts each accepted request into one single-beat AXI4 read or write transaction.
- Returns the load data and a stall request to the stall controller.
- Sits between the DT/MEM pipeline stages and the top-level AXI interconnect; one transaction outstanding at a time.

Parameters:
- AXI_ID, 4'd1, constant ARID/AWID value for data-side transactions

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- data_sram_en  in  1  request valid (held stable by pipeline while stallreq=1)
- data_sram_wen  in  4  byte write strobes; 0 = load
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  store data, already byte-lane positioned
- data_sram_pc  in  32  PC of requesting instruction (latched for debug only)
- data_sram_rdata  out  32  load data, valid in DONE cycle and held until next load completes
- stallreq  out  1  to stall controller; 1 = freeze pipeline up to DT
- arid/awid  out  4  = AXI_ID
- araddr, awaddr  out  32  transaction address
- arlen/awlen  out  8  always 0
- arsize/awsize  out  3  transfer size
- arburst/awburst  out  2  always 2'b01
- arvalid, arready, rdata[31:0], rresp[1:0], rlast, rvalid, rready  AR/R channels (master view)
- wdata[31:0], wstrb[3:0], wlast, wvalid, wready  W channel; wlast always 1
- bresp[1:0], bvalid, bready  B channel

Behaviour:
- Reset (resetn=0, async): state=IDLE; arvalid=awvalid=wvalid=0; rready=bready=0; stallreq=0; data_sram_rdata=0; latched addr/wdata/wstrb/pc=0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: if data_sram_en=1:
  - latch addr, wdata, wen, pc;
  - go to RD_ADDR if wen==0, else WR_REQ;
  - stallreq=1 combinationally in this same cycle.
  - If data_sram_en=0, stay in IDLE with stallreq=0.
- RD_ADDR:
  - arvalid=1; araddr = latched addr with [1:0] cleared; arsize=3'd2.
  - On arvalid&arready, go to RD_DATA; arvalid drops next cycle.
- RD_DATA:
  - rready=1.
  - On rvalid, capture rdata into data_sram_rdata and go to DONE.
  - rresp is ignored; rlast is not checked.
- WR_REQ:
  - awvalid=1 and wvalid=1 asserted together.
  - awaddr = latched addr.
  - awsize: 3'd2 for wen=1111; 3'd1 for 0011 or 1100; 3'd0 for any one-hot strobe.
  - wstrb = latched wen; wdata = latched wdata.
  - AW and W handshakes are tracked independently by two done flags. Each valid deasserts the cycle after its own handshake. The two may complete in the same cycle or in either order.
  - When both are done, go to WR_RESP.
- WR_RESP: bready=1; on bvalid go to DONE; bresp is ignored.
- DONE:
  - stallreq=0 for exactly one cycle, so the pipeline advances on this edge.
  - Unconditionally return to IDLE; a new request is not sampled in DONE.
- stallreq equals 1 in IDLE when en=1, and in RD_ADDR, RD_DATA, WR_REQ and WR_RESP. It is 0 in DONE and in idle-without-request.
- Latency (zero-wait slave): load = IDLE→RD_ADDR→RD_DATA→DONE, so the pipeline sees 3 stalled cycles. Store with AW and W accepted together = 3 stalled cycles.
- Valid signals never drop before their ready (AXI stability). Payload is held constant while valid=1.
- Reset mid-transaction: all valids drop immediately and the FSM returns to IDLE. Any outstanding slave response is not tracked.
- data_sram_rdata is updated only on R capture; stores leave it unchanged.

Test Plan:
- Load, zero-wait slave:
  - Stimulus: en=1, wen=0, addr=0x8000_1006; slave returns rdata=0xDEADBEEF.
  - Required: araddr=0x8000_1004, arsize=2; stallreq high 3 cycles; data_sram_rdata=0xDEADBEEF in DONE.
- Byte store, delayed ready:
  - Stimulus: wen=4'b0100, addr=0x1000_0002, wdata=0x00AB_0000; awready at cycle 4, wready at cycle 2.
  - Required: awsize=0; wstrb=0100; wvalid drops after cycle 2 while awvalid stays until cycle 4; B accepted; stallreq falls in DONE.
- Halfword and word store:
  - Stimulus: wen=1100 and then wen=1111.
  - Required: awsize=1 and then awsize=2; awlen=0, wlast=1 on both.
- Back-to-back requests:
  - Stimulus: load immediately followed by a store, en held high.
  - Required: exactly one AR and one AW/W; no duplicate transaction; DONE→IDLE gap visible between them.
- Slow R channel:
  - Stimulus: rvalid arrives 10 cycles after AR.
  - Required: stallreq stays 1 throughout; rdata is not updated early.
- Async reset:
  - Stimulus: resetn pulsed low in RD_DATA and in WR_REQ.
  - Required: all valids/readies and stallreq go to 0 without waiting for a clock edge; FSM is in IDLE after release.
